// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: width/rw/sign codes,
// FSM state encoding and the byte count for each access width.
package mem_ctrl_pkg;

    localparam logic [1:0] WIDE_BYTE = 2'b00;
    localparam logic [1:0] WIDE_HALF = 2'b01;
    localparam logic [1:0] WIDE_WORD = 2'b10;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        WAIT_LAST = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Encoding 2'b11 is handled as a full word
    function automatic logic [2:0] byte_count(input logic [1:0] wide);
        case (wide)
            WIDE_BYTE: byte_count = 3'd1;
            WIDE_HALF: byte_count = 3'd2;
            default:   byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ext.sv
// Load-data extender: sign or zero fills byte/half results to 32 bits.
// Purely combinational; word (and 2'b11) results pass through unchanged.
module mem_ext
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  wide,
    input  logic        sgn,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (wide)
            WIDE_BYTE: ext = {{24{(sgn == EXT_SIGN) && raw[7]}},  raw[7:0]};
            WIDE_HALF: ext = {{16{(sgn == EXT_SIGN) && raw[15]}}, raw[15:0]};
            default:   ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MEM onto one byte-wide sync RAM, serialising 1/2/4-byte accesses.
// Latency: reads done at t(N+2), writes at t(N+1); requesters stall until their done pulse.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic              mem_signed,
    input  logic [1:0]        mem_wide,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    state_t            state, state_nxt;
    logic [1:0]        cnt;
    logic [1:0]        cnt_inc;
    logic [1:0]        cap_idx;
    logic              owner_mem;
    logic              rw_q;
    logic              sgn_q;
    logic [1:0]        wide_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] raw_q;
    logic [DATA_W-1:0] raw_ins;
    logic [DATA_W-1:0] ext_ins;
    logic              last;

    assign cnt_inc = cnt + 2'd1;
    assign last    = ({1'b0, cnt} == (byte_count(wide_q) - 3'd1));

    assign if_done      = (state == DONE) && !owner_mem;
    assign mem_done     = (state == DONE) &&  owner_mem;
    assign stallreq_if  = if_req  && !if_done;
    assign stallreq_mem = mem_req && !mem_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (mem_req || if_req) state_nxt = ACCESS;
            ACCESS:    if (last) state_nxt = (rw_q == RW_WRITE) ? DONE : WAIT_LAST;
            WAIT_LAST: state_nxt = DONE;
            default:   state_nxt = IDLE;
        endcase
    end

    // RAM data lags its address by one cycle, so ACCESS fills byte cnt-1
    // and WAIT_LAST fills the final byte at cnt.
    always_comb begin
        cap_idx = (state == WAIT_LAST) ? cnt : (cnt - 2'd1);
        raw_ins = raw_q;
        raw_ins[{cap_idx, 3'b000} +: 8] = ram_din;
    end

    mem_ext u_ext (
        .raw  (raw_ins),
        .wide (wide_q),
        .sgn  (sgn_q),
        .ext  (ext_ins)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            owner_mem <= 1'b0;
            rw_q      <= RW_READ;
            sgn_q     <= EXT_ZERO;
            wide_q    <= WIDE_WORD;
            base_q    <= '0;
            wdata_q   <= '0;
            raw_q     <= '0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= 8'h00;
            if_data   <= '0;
            mem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // MEM wins a simultaneous request; IF keeps stalling until served
                    if (mem_req || if_req) begin
                        owner_mem <= mem_req;
                        rw_q      <= mem_req ? mem_rw : RW_READ;
                        sgn_q     <= mem_req ? mem_signed : EXT_ZERO;
                        wide_q    <= mem_req ? mem_wide : WIDE_WORD;
                        base_q    <= mem_req ? mem_addr : if_addr;
                        wdata_q   <= (mem_req && (mem_rw == RW_WRITE)) ? mem_wdata : '0;
                        raw_q     <= '0;
                        cnt       <= '0;
                        ram_a     <= mem_req ? mem_addr : if_addr;
                        ram_wr    <= mem_req && (mem_rw == RW_WRITE);
                        ram_dout  <= (mem_req && (mem_rw == RW_WRITE)) ? mem_wdata[7:0] : 8'h00;
                    end
                end
                ACCESS: begin
                    if ((rw_q == RW_READ) && (cnt != 2'd0)) begin
                        raw_q <= raw_ins;
                    end
                    if (last) begin
                        ram_wr <= 1'b0;
                    end else begin
                        cnt      <= cnt_inc;
                        ram_a    <= base_q + ADDR_W'(cnt_inc);
                        ram_dout <= wdata_q[{cnt_inc, 3'b000} +: 8];
                    end
                end
                WAIT_LAST: begin
                    if (owner_mem) begin
                        mem_rdata <= ext_ins;
                    end else begin
                        if_data <= raw_ins;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
